// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: pipeline control, inst_rom side and IF/ID outputs.
// Optional feature macro: FETCH_PERF_EN adds fetch_count_out / bubble_count_out.
//   slave  : the fetch stage (drives rom_addr_out and IF/ID fields)
//   master : the surrounding pipeline / ROM (drives control and rom_data_in)
interface fetch_stage_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
);
  logic              stall_in;
  logic              redirect_in;
  logic [ADDR_W-1:0] redirect_pc_in;
  logic [ADDR_W-1:0] rom_addr_out;
  logic [INST_W-1:0] rom_data_in;
  logic [ADDR_W-1:0] if_pc_out;
  logic [ADDR_W-1:0] if_pc_next_out;
  logic [INST_W-1:0] if_inst_out;
  logic              if_valid_out;
`ifdef FETCH_PERF_EN
  logic [31:0]       fetch_count_out;
  logic [31:0]       bubble_count_out;

  modport slave (
    input  stall_in, redirect_in, redirect_pc_in, rom_data_in,
    output rom_addr_out, if_pc_out, if_pc_next_out, if_inst_out, if_valid_out,
    output fetch_count_out, bubble_count_out
  );
  modport master (
    output stall_in, redirect_in, redirect_pc_in, rom_data_in,
    input  rom_addr_out, if_pc_out, if_pc_next_out, if_inst_out, if_valid_out,
    input  fetch_count_out, bubble_count_out
  );
`else
  modport slave (
    input  stall_in, redirect_in, redirect_pc_in, rom_data_in,
    output rom_addr_out, if_pc_out, if_pc_next_out, if_inst_out, if_valid_out
  );
  modport master (
    output stall_in, redirect_in, redirect_pc_in, rom_data_in,
    input  rom_addr_out, if_pc_out, if_pc_next_out, if_inst_out, if_valid_out
  );
`endif
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select (reset > redirect > stall > +PC_INC)
// and IF/ID pipeline register. rom_addr_out carries next_pc so that the synchronous
// inst_rom returns the instruction at the current PC one edge later.
// Optional feature macro: FETCH_PERF_EN (fetch / bubble saturating counters).
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high reset
//   bus    fetch_stage_if.slave: stall/redirect control, ROM address/data, IF/ID outputs
module fetch_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(32'h0040_0000),
  parameter int unsigned       PC_INC   = 4,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0000)
) (
  input  logic         clock,
  input  logic         reset,
  fetch_stage_if.slave bus
);
  localparam logic [ADDR_W-1:0] INC      = ADDR_W'(PC_INC);
  localparam logic [ADDR_W-1:0] ALIGN_MK = ~ADDR_W'(3);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] if_pc;
  logic [ADDR_W-1:0] if_pc_next;
  logic [INST_W-1:0] if_inst;
  logic              if_valid;

  // Next-PC select; redirect target is word-aligned.
  always_comb begin
    next_pc = pc + INC;
    if (reset) begin
      next_pc = PC_RESET;
    end else if (bus.redirect_in) begin
      next_pc = bus.redirect_pc_in & ALIGN_MK;
    end else if (bus.stall_in) begin
      next_pc = pc;
    end
  end

  assign bus.rom_addr_out = next_pc;

  // PC follows next_pc every edge; reset is already folded into next_pc.
  always_ff @(posedge clock) begin
    pc <= next_pc;
  end

  // IF/ID register: flush on redirect, hold on stall, capture ROM data otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      if_pc      <= PC_RESET;
      if_pc_next <= PC_RESET + INC;
      if_inst    <= NOP_INST;
      if_valid   <= 1'b0;
    end else if (bus.redirect_in) begin
      if_inst    <= NOP_INST;
      if_valid   <= 1'b0;
    end else if (!bus.stall_in) begin
      if_pc      <= pc;
      if_pc_next <= pc + INC;
      if_inst    <= bus.rom_data_in;
      if_valid   <= 1'b1;
    end
  end

  assign bus.if_pc_out      = if_pc;
  assign bus.if_pc_next_out = if_pc_next;
  assign bus.if_inst_out    = if_inst;
  assign bus.if_valid_out   = if_valid;

`ifdef FETCH_PERF_EN
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;

  // Saturating performance counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
    end else begin
      if (!bus.redirect_in && !bus.stall_in && fetch_cnt != CNT_MAX) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if ((bus.redirect_in || bus.stall_in) && bubble_cnt != CNT_MAX) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end

  assign bus.fetch_count_out  = fetch_cnt;
  assign bus.bubble_count_out = bubble_cnt;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage. The ROM model returns the word
// index (addr >> 2) one edge after the address is presented.
module tb_fetch_stage;
  localparam logic [31:0] PC_RST = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fetch_stage_if #(.ADDR_W(32), .INST_W(32)) b();

  fetch_stage dut (
    .clock (clk),
    .reset (rst),
    .bus   (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM model: data = word index of the registered address.
  always @(posedge clk) b.rom_data_in <= b.rom_addr_out >> 2;

  // IF/ID snapshot: {valid, pc, pc_next, inst}.
  function automatic logic [96:0] ifid();
    return {b.if_valid_out, b.if_pc_out, b.if_pc_next_out, b.if_inst_out};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [96:0] e;
    rst = 1'b1; b.stall_in = 1'b0; b.redirect_in = 1'b0; b.redirect_pc_in = '0;
    repeat (3) step();
    e = {1'b0, PC_RST, PC_RST + 32'd4, NOP};
    checks++;
    if (ifid() !== e) begin errors++; $display("FAIL reset_ifid got %h exp %h", ifid(), e); end
    checks++;
    if (b.rom_addr_out !== PC_RST) begin errors++; $display("FAIL reset_rom_addr got %h exp %h", b.rom_addr_out, PC_RST); end
    rst = 1'b0;
    #1;
    checks++;
    if (b.rom_addr_out !== 32'h0040_0004) begin errors++; $display("FAIL release_rom_addr got %h exp 00400004", b.rom_addr_out); end
    step();
    e = {1'b1, 32'h0040_0000, 32'h0040_0004, 32'h0010_0000};
    checks++;
    if (ifid() !== e) begin errors++; $display("FAIL first_fetch got %h exp %h", ifid(), e); end
    step();
    e = {1'b1, 32'h0040_0004, 32'h0040_0008, 32'h0010_0001};
    checks++;
    if (ifid() !== e) begin errors++; $display("FAIL second_fetch got %h exp %h", ifid(), e); end
  endtask

  task automatic test_stall();
    logic [96:0] e;
    b.stall_in = 1'b1;
    #1;
    checks++;
    if (b.rom_addr_out !== 32'h0040_0008) begin errors++; $display("FAIL stall_rom_addr got %h exp 00400008", b.rom_addr_out); end
    e = {1'b1, 32'h0040_0004, 32'h0040_0008, 32'h0010_0001};
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (ifid() !== e || b.rom_addr_out !== 32'h0040_0008) begin
        errors++; $display("FAIL stall_hold_%0d got %h addr %h exp %h addr 00400008", i, ifid(), b.rom_addr_out, e);
      end
    end
    b.stall_in = 1'b0;
    step();
    e = {1'b1, 32'h0040_0008, 32'h0040_000C, 32'h0010_0002};
    checks++;
    if (ifid() !== e) begin errors++; $display("FAIL stall_resume got %h exp %h", ifid(), e); end
    step();
    e = {1'b1, 32'h0040_000C, 32'h0040_0010, 32'h0010_0003};
    checks++;
    if (ifid() !== e) begin errors++; $display("FAIL stall_resume_next got %h exp %h", ifid(), e); end
  endtask

  task automatic test_redirect();
    logic [96:0] e;
    b.redirect_in = 1'b1; b.redirect_pc_in = 32'h0040_0103;
    #1;
    checks++;
    if (b.rom_addr_out !== 32'h0040_0100) begin errors++; $display("FAIL redirect_rom_addr got %h exp 00400100", b.rom_addr_out); end
    step();
    b.redirect_in = 1'b0;
    e = {1'b0, 32'h0040_000C, 32'h0040_0010, NOP};
    checks++;
    if (ifid() !== e) begin errors++; $display("FAIL redirect_bubble got %h exp %h", ifid(), e); end
    step();
    e = {1'b1, 32'h0040_0100, 32'h0040_0104, 32'h0010_0040};
    checks++;
    if (ifid() !== e) begin errors++; $display("FAIL redirect_target got %h exp %h", ifid(), e); end
  endtask

  task automatic test_stall_redirect();
    logic [96:0] e;
    b.stall_in = 1'b1; b.redirect_in = 1'b1; b.redirect_pc_in = 32'h0040_0200;
    #1;
    checks++;
    if (b.rom_addr_out !== 32'h0040_0200) begin errors++; $display("FAIL both_rom_addr got %h exp 00400200", b.rom_addr_out); end
    step();
    b.stall_in = 1'b0; b.redirect_in = 1'b0;
    checks++;
    if (b.if_valid_out !== 1'b0 || b.if_inst_out !== NOP) begin
      errors++; $display("FAIL both_bubble got valid %b inst %h exp valid 0 inst %h", b.if_valid_out, b.if_inst_out, NOP);
    end
    step();
    e = {1'b1, 32'h0040_0200, 32'h0040_0204, 32'h0010_0080};
    checks++;
    if (ifid() !== e) begin errors++; $display("FAIL both_target got %h exp %h", ifid(), e); end
  endtask

  task automatic test_wrap();
    logic [96:0] e;
    b.redirect_in = 1'b1; b.redirect_pc_in = 32'hFFFF_FFFC;
    step();
    b.redirect_in = 1'b0;
    #1;
    checks++;
    if (b.rom_addr_out !== 32'h0000_0000) begin errors++; $display("FAIL wrap_rom_addr got %h exp 00000000", b.rom_addr_out); end
    step();
    e = {1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h3FFF_FFFF};
    checks++;
    if (ifid() !== e) begin errors++; $display("FAIL wrap_top got %h exp %h", ifid(), e); end
    step();
    e = {1'b1, 32'h0000_0000, 32'h0000_0004, 32'h0000_0000};
    checks++;
    if (ifid() !== e) begin errors++; $display("FAIL wrap_zero got %h exp %h", ifid(), e); end
  endtask

  task automatic test_reset_override();
    logic [96:0] e;
    b.stall_in = 1'b1;
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (b.rom_addr_out !== PC_RST) begin errors++; $display("FAIL rst_stall_rom_addr got %h exp %h", b.rom_addr_out, PC_RST); end
    step();
    e = {1'b0, PC_RST, PC_RST + 32'd4, NOP};
    checks++;
    if (ifid() !== e) begin errors++; $display("FAIL rst_stall_ifid got %h exp %h", ifid(), e); end
    b.stall_in = 1'b0; b.redirect_in = 1'b1; b.redirect_pc_in = 32'h0000_0500;
    step();
    checks++;
    if (ifid() !== e) begin errors++; $display("FAIL rst_redir_ifid got %h exp %h", ifid(), e); end
    rst = 1'b0; b.redirect_in = 1'b0;
    #1;
    checks++;
    if (b.rom_addr_out !== 32'h0040_0004) begin errors++; $display("FAIL rst_redir_rom_addr got %h exp 00400004", b.rom_addr_out); end
    step();
    e = {1'b1, PC_RST, PC_RST + 32'd4, 32'h0010_0000};
    checks++;
    if (ifid() !== e) begin errors++; $display("FAIL rst_recover got %h exp %h", ifid(), e); end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    rst = 1'b1; b.stall_in = 1'b0; b.redirect_in = 1'b0;
    step();
    checks++;
    if (b.fetch_count_out !== 32'd0 || b.bubble_count_out !== 32'd0) begin
      errors++; $display("FAIL perf_reset got %0d/%0d exp 0/0", b.fetch_count_out, b.bubble_count_out);
    end
    rst = 1'b0;
    repeat (10) step();
    b.stall_in = 1'b1;
    repeat (3) step();
    b.stall_in = 1'b0; b.redirect_in = 1'b1; b.redirect_pc_in = 32'h0040_0100;
    step();
    b.redirect_in = 1'b0;
    checks++;
    if (b.fetch_count_out !== 32'd10 || b.bubble_count_out !== 32'd4) begin
      errors++; $display("FAIL perf_counts got %0d/%0d exp 10/4", b.fetch_count_out, b.bubble_count_out);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    b.stall_in = 1'b0;
    b.redirect_in = 1'b0;
    b.redirect_pc_in = '0;
    test_reset();
    test_stall();
    test_redirect();
    test_stall_redirect();
    test_wrap();
    test_reset_override();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
